// File: rtl/spi_flash_responder.sv
// -----------------------------------------------------------------------------
// spi_flash_responder
//
// Device-end SPI flash model. It stands in for a 25-series serial flash
// and is fully synthesizable. SCK, CS_N and COPI are oversampled on clk_i,
// so the host SCK period must be at least 8 clk_i cycles. The block decodes
// READ (0x03), READ JEDEC ID (0x9F) and READ STATUS (0x05), and serves
// reads from an internal byte memory. That memory is loaded through a
// backdoor write port.
//
// Optional feature, enabled by defining SPI_FLASH_RESP_PROGRAM_EN:
//   WRITE ENABLE (0x06), WRITE DISABLE (0x04) and PAGE PROGRAM (0x02).
// When the macro is undefined, these commands are ignored and WEL reads 0.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   spi_sck_i      SPI clock from the host (mode 0)
//   spi_cs_ni      chip select, active low
//   spi_copi_i     host-to-device serial data
//   spi_cipo_o     device-to-host serial data
//   spi_cipo_en_o  high while the responder drives CIPO
//   mem_we_i       backdoor write strobe
//   mem_addr_i     backdoor byte address
//   mem_wdata_i    backdoor write data
//   busy_o         high while a transaction is in progress (synchronized CS low)
// -----------------------------------------------------------------------------
module spi_flash_responder #(
  parameter int unsigned MemDepthBytes = 4096,
  parameter logic [23:0] JedecId       = 24'hEF4016
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             spi_sck_i,
  input  logic                             spi_cs_ni,
  input  logic                             spi_copi_i,
  output logic                             spi_cipo_o,
  output logic                             spi_cipo_en_o,
  input  logic                             mem_we_i,
  input  logic [$clog2(MemDepthBytes)-1:0] mem_addr_i,
  input  logic [7:0]                       mem_wdata_i,
  output logic                             busy_o
);

  localparam int unsigned AW = $clog2(MemDepthBytes);

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StData,
    StIgnore,
    StProg
  } state_e;

  typedef enum logic [1:0] {
    SrcMem,
    SrcId,
    SrcStatus
  } src_e;

  // ---------------------------------------------------------------------------
  // Input synchronizers. The bit order is {sck, cs_n, copi}. CS_N resets to
  // its idle-high level, so busy_o comes out of reset low.
  // ---------------------------------------------------------------------------
  localparam logic [2:0] SyncRstVal = 3'b010;

  logic [2:0] sync_in;
  logic [2:0] sync_out;
  assign sync_in = {spi_sck_i, spi_cs_ni, spi_copi_i};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    logic meta_reg;
    logic stable_reg;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        meta_reg   <= SyncRstVal[gi];
        stable_reg <= SyncRstVal[gi];
      end else begin
        meta_reg   <= sync_in[gi];
        stable_reg <= meta_reg;
      end
    end
    assign sync_out[gi] = stable_reg;
  end

  logic sck_s, cs_n_s, copi_s;
  assign {sck_s, cs_n_s, copi_s} = sync_out;

  logic sck_prev_reg;
  logic sck_rise, sck_fall;
  assign sck_rise = sck_s & ~sck_prev_reg;
  assign sck_fall = ~sck_s & sck_prev_reg;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_reg,    state_next;
  src_e        src_reg,      src_next;
  logic [4:0]  bit_cnt_reg,  bit_cnt_next;
  logic [22:0] rx_shift_reg, rx_shift_next;
  logic [6:0]  tx_shift_reg, tx_shift_next;
  logic [2:0]  tx_cnt_reg,   tx_cnt_next;
  logic [1:0]  id_idx_reg,   id_idx_next;
  logic [AW-1:0] mem_addr_reg, mem_addr_next;
  logic        cipo_reg,     cipo_next;
  logic        cipo_en_reg,  cipo_en_next;

  // The received word includes the bit arriving on this SCK rising edge.
  logic [23:0] rx_word;
  assign rx_word = {rx_shift_reg, copi_s};

  // Address bits above the memory size alias and are dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^rx_word[23:AW];

  // Memory ports
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data_reg;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  logic wel;

`ifdef SPI_FLASH_RESP_PROGRAM_EN
  logic          wel_reg,       wel_next;
  logic          prog_seen_reg, prog_seen_next;
  logic          prog_mode_reg, prog_mode_next;
  logic          prog_pend_reg, prog_pend_next;
  logic [AW-1:0] prog_addr_reg, prog_addr_next;
  logic [7:0]    prog_data_reg, prog_data_next;

  assign wel = wel_reg;

  // The backdoor wins the single write port. A pending program byte waits
  // until the port is free.
  assign wr_en   = mem_we_i | prog_pend_reg;
  assign wr_addr = mem_we_i ? mem_addr_i  : prog_addr_reg;
  assign wr_data = mem_we_i ? mem_wdata_i : prog_data_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wel_reg       <= 1'b0;
      prog_seen_reg <= 1'b0;
      prog_mode_reg <= 1'b0;
      prog_pend_reg <= 1'b0;
      prog_addr_reg <= '0;
      prog_data_reg <= 8'h00;
    end else begin
      wel_reg       <= wel_next;
      prog_seen_reg <= prog_seen_next;
      prog_mode_reg <= prog_mode_next;
      prog_pend_reg <= prog_pend_next;
      prog_addr_reg <= prog_addr_next;
      prog_data_reg <= prog_data_next;
    end
  end
`else
  assign wel     = 1'b0;
  assign wr_en   = mem_we_i;
  assign wr_addr = mem_addr_i;
  assign wr_data = mem_wdata_i;
`endif

  // ---------------------------------------------------------------------------
  // Byte memory. A read in the same cycle as a write returns the old data.
  // ---------------------------------------------------------------------------
  logic [7:0] mem [MemDepthBytes];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_reg  <= mem[rd_addr];
  end

  // Next byte to be loaded into the transmit shifter
  logic [7:0] cur_byte;
  always_comb begin
    cur_byte = 8'h00;
    case (src_reg)
      SrcMem:    cur_byte = rd_data_reg;
      SrcId: begin
        case (id_idx_reg)
          2'd0:    cur_byte = JedecId[23:16];
          2'd1:    cur_byte = JedecId[15:8];
          2'd2:    cur_byte = JedecId[7:0];
          default: cur_byte = 8'h00;
        endcase
      end
      SrcStatus: cur_byte = {6'b000000, wel, 1'b0};
      default:   cur_byte = 8'h00;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_prev_reg <= 1'b0;
      state_reg    <= StIdle;
      src_reg      <= SrcMem;
      bit_cnt_reg  <= '0;
      rx_shift_reg <= '0;
      tx_shift_reg <= '0;
      tx_cnt_reg   <= '0;
      id_idx_reg   <= '0;
      mem_addr_reg <= '0;
      cipo_reg     <= 1'b0;
      cipo_en_reg  <= 1'b0;
    end else begin
      sck_prev_reg <= sck_s;
      state_reg    <= state_next;
      src_reg      <= src_next;
      bit_cnt_reg  <= bit_cnt_next;
      rx_shift_reg <= rx_shift_next;
      tx_shift_reg <= tx_shift_next;
      tx_cnt_reg   <= tx_cnt_next;
      id_idx_reg   <= id_idx_next;
      mem_addr_reg <= mem_addr_next;
      cipo_reg     <= cipo_next;
      cipo_en_reg  <= cipo_en_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    src_next      = src_reg;
    bit_cnt_next  = bit_cnt_reg;
    rx_shift_next = rx_shift_reg;
    tx_shift_next = tx_shift_reg;
    tx_cnt_next   = tx_cnt_reg;
    id_idx_next   = id_idx_reg;
    mem_addr_next = mem_addr_reg;
    cipo_next     = cipo_reg;
    rd_en         = 1'b0;
    rd_addr       = mem_addr_reg;
`ifdef SPI_FLASH_RESP_PROGRAM_EN
    wel_next       = wel_reg;
    prog_seen_next = prog_seen_reg;
    prog_mode_next = prog_mode_reg;
    prog_pend_next = prog_pend_reg;
    prog_addr_next = prog_addr_reg;
    prog_data_next = prog_data_reg;
    // A pending program byte retires on any cycle without a backdoor write.
    if (prog_pend_reg && !mem_we_i) prog_pend_next = 1'b0;
`endif

    if (cs_n_s) begin
      // CS high aborts everything. Partial bits are simply dropped.
      state_next = StIdle;
`ifdef SPI_FLASH_RESP_PROGRAM_EN
      prog_mode_next = 1'b0;
      if (prog_seen_reg) begin
        wel_next       = 1'b0;
        prog_seen_next = 1'b0;
      end
`endif
    end else begin
      case (state_reg)
        StIdle: begin
          state_next   = StCmd;
          bit_cnt_next = '0;
        end

        StCmd: begin
          if (sck_rise) begin
            rx_shift_next = rx_word[22:0];
            bit_cnt_next  = bit_cnt_reg + 5'd1;
            if (bit_cnt_reg == 5'd7) begin
              bit_cnt_next = '0;
              tx_cnt_next  = '0;
              case (rx_word[7:0])
                8'h03: state_next = StAddr;
                8'h9F: begin
                  state_next  = StData;
                  src_next    = SrcId;
                  id_idx_next = '0;
                end
                8'h05: begin
                  state_next = StData;
                  src_next   = SrcStatus;
                end
`ifdef SPI_FLASH_RESP_PROGRAM_EN
                8'h06: begin
                  wel_next   = 1'b1;
                  state_next = StIgnore;
                end
                8'h04: begin
                  wel_next   = 1'b0;
                  state_next = StIgnore;
                end
                8'h02: begin
                  prog_seen_next = 1'b1;
                  if (wel_reg) begin
                    prog_mode_next = 1'b1;
                    state_next     = StAddr;
                  end else begin
                    state_next = StIgnore;
                  end
                end
`endif
                default: state_next = StIgnore;
              endcase
            end
          end
        end

        StAddr: begin
          if (sck_rise) begin
            rx_shift_next = rx_word[22:0];
            bit_cnt_next  = bit_cnt_reg + 5'd1;
            if (bit_cnt_reg == 5'd23) begin
              bit_cnt_next  = '0;
              mem_addr_next = rx_word[AW-1:0];
`ifdef SPI_FLASH_RESP_PROGRAM_EN
              if (prog_mode_reg) begin
                state_next = StProg;
              end else
`endif
              begin
                // Fetch the first byte now. It is needed no earlier than the
                // next SCK falling edge.
                rd_en       = 1'b1;
                rd_addr     = rx_word[AW-1:0];
                src_next    = SrcMem;
                tx_cnt_next = '0;
                state_next  = StData;
              end
            end
          end
        end

        StData: begin
          if (sck_fall) begin
            tx_cnt_next = tx_cnt_reg + 3'd1;
            if (tx_cnt_reg == 3'd0) begin
              // Byte boundary: drive the MSB of the next byte and advance
              // the source.
              cipo_next     = cur_byte[7];
              tx_shift_next = cur_byte[6:0];
              case (src_reg)
                SrcMem: begin
                  // Prefetch the following byte straight away.
                  mem_addr_next = mem_addr_reg + 1'b1;
                  rd_en         = 1'b1;
                  rd_addr       = mem_addr_reg + 1'b1;
                end
                SrcId: begin
                  if (id_idx_reg != 2'd3) id_idx_next = id_idx_reg + 2'd1;
                end
                default: ;
              endcase
            end else begin
              cipo_next     = tx_shift_reg[6];
              tx_shift_next = {tx_shift_reg[5:0], 1'b0};
            end
          end
        end

`ifdef SPI_FLASH_RESP_PROGRAM_EN
        StProg: begin
          if (sck_rise) begin
            rx_shift_next = rx_word[22:0];
            bit_cnt_next  = bit_cnt_reg + 5'd1;
            if (bit_cnt_reg == 5'd7) begin
              bit_cnt_next   = '0;
              prog_pend_next = 1'b1;
              prog_addr_next = mem_addr_reg;
              prog_data_next = rx_word[7:0];
              // Advance within the 256-byte page only.
              mem_addr_next  = {mem_addr_reg[AW-1:8], mem_addr_reg[7:0] + 8'd1};
            end
          end
        end
`endif

        default: ;  // StIgnore waits for CS to rise
      endcase
    end

    cipo_en_next = (state_next == StData);
    if (state_next != StData) cipo_next = 1'b0;
  end

  assign spi_cipo_o    = cipo_reg;
  assign spi_cipo_en_o = cipo_en_reg;
  assign busy_o        = ~cs_n_s;

endmodule
